// File: rtl/bcd_seq_conv_pkg.sv
// -----------------------------------------------------------------------------
// bcd_seq_conv_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding constants
//   - max_dec(): largest value representable in a given number of BCD digits
//   - nines(): all-nines saturation pattern for a given number of digits
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_seq_conv_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Upper bound on the digit count; sizes the saturation pattern.
    localparam int MAX_DIGITS = 5;

    // 10^digits - 1
    function automatic int unsigned max_dec(input int digits);
        int unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    // Packed BCD with the low 'digits' nibbles set to 9, upper nibbles zero.
    function automatic logic [4*MAX_DIGITS-1:0] nines(input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'h9;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seq_conv_if.sv
// -----------------------------------------------------------------------------
// bcd_seq_conv_if
// Start/busy/done handshake bundle between a requester and bcd_seq_conv.
//   start : request, sampled at clk rising edge
//   bin   : unsigned binary value, IN_W bits
//   busy  : conversion in progress
//   done  : one-cycle result-valid pulse
//   bcd   : packed BCD result, 4*DIGITS bits, MS digit in top nibble
//   ovf   : input exceeded 10^DIGITS-1 (bcd saturated to all nines)
// Modports: master (requester side), slave (converter side).
// -----------------------------------------------------------------------------
interface bcd_seq_conv_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [IN_W-1:0]       bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bcd_seq_conv_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble cell: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   din  : 4-bit BCD digit before adjustment
//   dout : adjusted digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_seq_conv.sv
// -----------------------------------------------------------------------------
// bcd_seq_conv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock).
// A conversion started on edge E0 raises done for one cycle after edge
// E0+IN_W. Inputs above 10^DIGITS-1 saturate to all nines and set ovf.
//   clk : system clock
//   rst : synchronous active-low reset, clears every register
//   bus : bcd_seq_conv_if slave (start, bin, busy, done, bcd, ovf)
// -----------------------------------------------------------------------------
module bcd_seq_conv
    import bcd_seq_conv_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    bcd_seq_conv_if.slave  bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam int unsigned MAX_DEC = max_dec(DIGITS);
    localparam logic [4*MAX_DIGITS-1:0] NINES_ALL = nines(DIGITS);
    localparam logic [SW-1:0] NINES = NINES_ALL[SW-1:0];

    logic [1:0]      state;
    logic [IN_W-1:0] shreg;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            ovf_pend;
    logic            busy_r;
    logic            done_r;
    logic [SW-1:0]   bcd_r;
    logic            ovf_r;
    logic [SW-1:0]   scratch_nxt;
    logic            in_ovf;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Adjusted digits shifted left with the next binary bit entering the LSB.
    assign scratch_nxt = {adj[SW-2:0], shreg[IN_W-1]};
    // Overflow decided up-front so truncated upper digits never matter.
    assign in_ovf      = 32'(bus.bin) > MAX_DEC;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            bcd_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shreg    <= bus.bin;
                        scratch  <= '0;
                        cnt      <= CW'(IN_W);
                        ovf_pend <= in_ovf;
                        busy_r   <= 1'b1;
                        state    <= ST_SHIFT;
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= {shreg[IN_W-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= ST_FINISH;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        ovf_r  <= ovf_pend;
                        bcd_r  <= ovf_pend ? NINES : scratch_nxt;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// -----------------------------------------------------------------------------
// tb_bcd_seq_conv
// Self-checking bench for bcd_seq_conv: one instance with IN_W=8/DIGITS=3 and
// one with IN_W=10/DIGITS=3. Expected results come from a decimal arithmetic
// reference model.
// -----------------------------------------------------------------------------
module tb_bcd_seq_conv;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    bcd_seq_conv_if #(.IN_W(8),  .DIGITS(3)) b8 ();
    bcd_seq_conv_if #(.IN_W(10), .DIGITS(3)) b10 ();

    bcd_seq_conv #(.IN_W(8), .DIGITS(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    bcd_seq_conv #(.IN_W(10), .DIGITS(3)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (b10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ovf, bcd[11:0]} for a 3-digit converter, from decimal arithmetic.
    function automatic logic [12:0] ref_conv(input int unsigned v);
        if (v > 999) return {1'b1, 12'h999};
        return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] v, input string tag);
        logic [12:0] r;
        int n, bc;
        r = ref_conv(v);
        b8.start = 1'b1;
        b8.bin   = v;
        tick();
        b8.start = 1'b0;
        b8.bin   = 8'($urandom);
        n = 0;
        bc = 0;
        while (b8.done !== 1'b1 && n < 40) begin
            if (b8.busy === 1'b1) bc++;
            tick();
            n++;
        end
        check({tag, " latency"}, n, 8);
        check({tag, " busy_cycles"}, bc, 8);
        check({tag, " busy_in_finish"}, b8.busy, 0);
        check({tag, " bcd"}, b8.bcd, r[11:0]);
        check({tag, " ovf"}, b8.ovf, r[12]);
        tick();
        check({tag, " done_width"}, b8.done, 0);
    endtask

    task automatic run10(input logic [9:0] v, input string tag);
        logic [12:0] r;
        int n;
        r = ref_conv(v);
        b10.start = 1'b1;
        b10.bin   = v;
        tick();
        b10.start = 1'b0;
        b10.bin   = 10'($urandom);
        n = 0;
        while (b10.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 10);
        check({tag, " bcd"}, b10.bcd, r[11:0]);
        check({tag, " ovf"}, b10.ovf, r[12]);
        tick();
        check({tag, " done_width"}, b10.done, 0);
    endtask

    initial begin
        int n, dones;
        logic [7:0] rv8;
        logic [9:0] rv10;
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        b8.start  = 1'b0;
        b8.bin    = '0;
        b10.start = 1'b0;
        b10.bin   = '0;
        repeat (3) tick();

        check("rst busy", b8.busy, 0);
        check("rst done", b8.done, 0);
        check("rst bcd", b8.bcd, 0);
        check("rst ovf", b8.ovf, 0);
        check("rst10 bcd", b10.bcd, 0);
        rst = 1'b1;
        tick();

        // Directed values
        run8(8'd255, "v255");
        run8(8'd0,   "v0");
        run8(8'd99,  "v99");
        run8(8'd100, "v100");

        // Start during SHIFT is ignored
        b8.start = 1'b1;
        b8.bin   = 8'd37;
        tick();
        b8.start = 1'b0;
        repeat (2) tick();
        b8.start = 1'b1;
        b8.bin   = 8'd200;
        tick();
        b8.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (b8.done === 1'b1) begin
                dones++;
                check("ignore bcd", b8.bcd, 12'h037);
            end
            tick();
        end
        check("ignore done_count", dones, 1);
        check("ignore idle_busy", b8.busy, 0);

        // Back-to-back: restart in the FINISH cycle
        b8.start = 1'b1;
        b8.bin   = 8'd12;
        tick();
        b8.start = 1'b0;
        n = 0;
        while (b8.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("b2b first_bcd", b8.bcd, 12'h012);
        check("b2b finish_busy", b8.busy, 0);
        b8.start = 1'b1;
        b8.bin   = 8'd201;
        tick();
        b8.start = 1'b0;
        check("b2b restart_busy", b8.busy, 1);
        check("b2b restart_done", b8.done, 0);
        n = 1;
        while (b8.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("b2b gap", n, 9);
        check("b2b second_bcd", b8.bcd, 12'h201);
        tick();

        // Randomized 8-bit values
        for (int i = 0; i < 8; i++) begin
            rv8 = 8'($urandom);
            run8(rv8, "rand8");
        end

        // 10-bit instance: saturation boundaries and random values
        run10(10'd1000, "w10_1000");
        run10(10'd999,  "w10_999");
        run10(10'd1023, "w10_1023");
        for (int i = 0; i < 5; i++) begin
            rv10 = 10'($urandom);
            run10(rv10, "rand10");
        end

        // Reset mid-conversion
        b8.start = 1'b1;
        b8.bin   = 8'd128;
        tick();
        b8.start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst busy", b8.busy, 0);
        check("midrst done", b8.done, 0);
        check("midrst bcd", b8.bcd, 0);
        check("midrst ovf", b8.ovf, 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (b8.done === 1'b1) dones++;
            tick();
        end
        check("midrst no_done", dones, 0);
        run8(8'd64, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
